// File: rtl/dds_pkg.sv
// dds_pkg: opcodes, system codes and FSM encoding shared by the DDS command controller.
package dds_pkg;
    localparam logic [1:0] OP_FTW = 2'b00, OP_PHASE = 2'b01, OP_CTRL = 2'b10, OP_SYS = 2'b11;
    localparam logic [5:0] SYS_NOP = 6'h00, SYS_COMMIT = 6'h01, SYS_COMMIT_WRAP = 6'h02, SYS_CLEAR = 6'h3F;
    localparam logic [1:0] ST_IDLE = 2'd0, ST_EXEC = 2'd1, ST_WAIT_WRAP = 2'd2;
endpackage

// File: rtl/dds_ch_regs.sv
// dds_ch_regs: one channel's shadow and active FTW, phase and control registers.
module dds_ch_regs #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic                  we_ftw,
    input  logic                  we_phase,
    input  logic                  we_ctrl,
    input  logic                  clr,
    input  logic                  commit,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] ftw,
    output logic [DATA_WIDTH-1:0] phase,
    output logic [1:0]            wave,
    output logic                  en
);
    logic [DATA_WIDTH-1:0] ftw_sh, phase_sh;
    logic [2:0]            ctrl_sh;
    always_ff @(posedge sys_clk or posedge rst)
        if (rst) begin
            ftw_sh   <= '0;
            phase_sh <= '0;
            ctrl_sh  <= '0;
            ftw      <= '0;
            phase    <= '0;
            wave     <= '0;
            en       <= 1'b0;
        end else begin
            if (clr) begin
                ftw_sh   <= '0;
                phase_sh <= '0;
                ctrl_sh  <= '0;
            end else begin
                if (we_ftw) ftw_sh <= data;
                if (we_phase) phase_sh <= data;
                if (we_ctrl) ctrl_sh <= data[2:0];
            end
            if (commit) begin
                ftw   <= ftw_sh;
                phase <= phase_sh;
                {en, wave} <= ctrl_sh;
            end
        end
endmodule

// File: rtl/dds_cmd_ctrl.sv
// dds_cmd_ctrl: decodes DDS commands into per-channel shadow writes and synchronous commits.
module dds_cmd_ctrl
    import dds_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int DATA_WIDTH = 16
) (
    input  logic                         sys_clk,
    input  logic                         rst,
    input  logic [7:0]                   cmd_word,
    input  logic [DATA_WIDTH-1:0]        data_word,
    input  logic                         cmd_valid,
    input  logic                         acc_wrap,
    output logic [NUM_CH*DATA_WIDTH-1:0] ftw_out,
    output logic [NUM_CH*DATA_WIDTH-1:0] phase_out,
    output logic [NUM_CH*2-1:0]          wave_sel,
    output logic [NUM_CH-1:0]            ch_en,
    output logic                         update_pulse,
    output logic                         busy,
    output logic [7:0]                   err_count
);
    localparam logic [6:0] NCH = 7'(NUM_CH);
    logic [1:0]            state, op;
    logic [5:0]            arg;
    logic [7:0]            cur_cmd, pend_cmd;
    logic [DATA_WIDTH-1:0] cur_data, pend_data;
    logic                  prev_valid, pend_v, cmd_edge, exec, legal, do_sys, go_wait, clr, commit;
    logic                  wrap_commit, bad, take_pend, start, cap_new, cap_pend, drop;
    logic [8:0]            err_sum;
    assign cmd_edge    = cmd_valid & ~prev_valid;
    assign op          = cur_cmd[7:6];
    assign arg         = cur_cmd[5:0];
    assign exec        = state == ST_EXEC;
    assign legal       = op == OP_SYS ? (arg == SYS_NOP || arg == SYS_COMMIT || arg == SYS_COMMIT_WRAP || arg == SYS_CLEAR)
                                      : {1'b0, arg} < NCH;
    assign bad         = exec & ~legal;
    assign do_sys      = exec & legal & op == OP_SYS;
    assign go_wait     = do_sys & arg == SYS_COMMIT_WRAP;
    assign clr         = do_sys & arg == SYS_CLEAR;
    assign wrap_commit = state == ST_WAIT_WRAP & acc_wrap;
    assign commit      = (do_sys & arg == SYS_COMMIT) | wrap_commit;
    // A finishing operation hands straight over to the pending command, else to a fresh edge.
    assign take_pend   = pend_v & ((exec & ~go_wait) | wrap_commit);
    assign start       = (state == ST_IDLE & cmd_edge) | (((exec & ~go_wait) | wrap_commit) & (pend_v | cmd_edge));
    assign cap_new     = cmd_edge & state != ST_IDLE & ~start & ~pend_v;
    assign cap_pend    = cap_new | (take_pend & cmd_edge);
    assign drop        = cmd_edge & pend_v & ~take_pend;
    assign err_sum     = {1'b0, err_count} + {8'd0, bad} + {8'd0, drop};
    assign busy        = state != ST_IDLE | pend_v;
    always_ff @(posedge sys_clk or posedge rst)
        if (rst) begin
            state        <= ST_IDLE;
            prev_valid   <= 1'b0;
            pend_v       <= 1'b0;
            cur_cmd      <= '0;
            cur_data     <= '0;
            pend_cmd     <= '0;
            pend_data    <= '0;
            update_pulse <= 1'b0;
            err_count    <= '0;
        end else begin
            prev_valid   <= cmd_valid;
            update_pulse <= commit;
            err_count    <= err_sum[8] ? 8'hFF : err_sum[7:0];
            state        <= start ? ST_EXEC : go_wait ? ST_WAIT_WRAP : (exec | wrap_commit) ? ST_IDLE : state;
            pend_v       <= take_pend ? cmd_edge : pend_v | cap_new;
            if (start) begin
                cur_cmd  <= pend_v ? pend_cmd : cmd_word;
                cur_data <= pend_v ? pend_data : data_word;
            end
            if (cap_pend) begin
                pend_cmd  <= cmd_word;
                pend_data <= data_word;
            end
        end
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [5:0] ID = 6'(i);
        dds_ch_regs #(.DATA_WIDTH(DATA_WIDTH)) u_ch (
            .sys_clk (sys_clk),
            .rst     (rst),
            .we_ftw  (exec & op == OP_FTW & arg == ID),
            .we_phase(exec & op == OP_PHASE & arg == ID),
            .we_ctrl (exec & op == OP_CTRL & arg == ID),
            .clr     (clr),
            .commit  (commit),
            .data    (cur_data),
            .ftw     (ftw_out[i*DATA_WIDTH +: DATA_WIDTH]),
            .phase   (phase_out[i*DATA_WIDTH +: DATA_WIDTH]),
            .wave    (wave_sel[i*2 +: 2]),
            .en      (ch_en[i])
        );
    end
endmodule

// File: tb/tb_dds_cmd_ctrl.sv
// tb_dds_cmd_ctrl: scoreboard bench; every commit pushes the expected active image, update_pulse pops it.
module tb_dds_cmd_ctrl;
    typedef struct packed {
        logic [31:0] f;
        logic [31:0] p;
        logic [3:0]  w;
        logic [1:0]  e;
    } snap_t;
    logic        sys_clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, acc_wrap = 1'b0;
    logic [7:0]  cmd_word = '0;
    logic [15:0] data_word = '0;
    logic [31:0] ftw_out, phase_out;
    logic [3:0]  wave_sel;
    logic [1:0]  ch_en;
    logic        update_pulse, busy;
    logic [7:0]  err_count;
    int          n_tests = 0, n_fail = 0;
    snap_t       sb[$];
    snap_t       act = '0, mon_e;
    logic [15:0] m_ftw[2], m_ph[2];
    logic [2:0]  m_ctl[2];
    logic [7:0]  err_exp = '0;
    logic        ok_busy, ok_ph;

    dds_cmd_ctrl #(.NUM_CH(2), .DATA_WIDTH(16)) dut (
        .sys_clk(sys_clk), .rst(rst), .cmd_word(cmd_word), .data_word(data_word),
        .cmd_valid(cmd_valid), .acc_wrap(acc_wrap), .ftw_out(ftw_out), .phase_out(phase_out),
        .wave_sel(wave_sel), .ch_en(ch_en), .update_pulse(update_pulse), .busy(busy),
        .err_count(err_count)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic snap_t snap();
        snap_t s;
        s.f = {m_ftw[1], m_ftw[0]};
        s.p = {m_ph[1], m_ph[0]};
        s.w = {m_ctl[1][1:0], m_ctl[0][1:0]};
        s.e = {m_ctl[1][2], m_ctl[0][2]};
        return s;
    endfunction

    task automatic bump_err();
        if (err_exp != 8'hFF) err_exp++;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 2; i++) begin
            m_ftw[i] = '0;
            m_ph[i]  = '0;
            m_ctl[i] = '0;
        end
    endtask

    task automatic model(input logic [7:0] c, input logic [15:0] d);
        int a;
        a = int'(c[5:0]);
        if (c[7:6] == 2'b11) begin
            if (a == 1 || a == 2) sb.push_back(snap());
            else if (a == 63) clear_model();
            else if (a != 0) bump_err();
        end else if (a >= 2) bump_err();
        else if (c[7:6] == 2'b00) m_ftw[a] = d;
        else if (c[7:6] == 2'b01) m_ph[a] = d;
        else m_ctl[a] = d[2:0];
    endtask

    task automatic send(input logic [7:0] c, input logic [15:0] d, input bit dropped = 0, input bit wrap = 0);
        @(negedge sys_clk);
        cmd_word  = c;
        data_word = d;
        cmd_valid = 1'b1;
        acc_wrap  = wrap;
        if (dropped) bump_err();
        else model(c, d);
        @(negedge sys_clk);
        cmd_valid = 1'b0;
        acc_wrap  = 1'b0;
    endtask

    task automatic wrap_pulse();
        @(negedge sys_clk);
        acc_wrap = 1'b1;
        @(negedge sys_clk);
        acc_wrap = 1'b0;
    endtask

    always @(negedge sys_clk)
        if (!rst && update_pulse) begin
            if (sb.size() == 0) check("sb_underflow", 32'd1, 32'd0);
            else begin
                mon_e = sb.pop_front();
                act   = mon_e;
                check("sb_ftw", ftw_out, mon_e.f);
                check("sb_phase", phase_out, mon_e.p);
                check("sb_wave", {28'd0, wave_sel}, {28'd0, mon_e.w});
                check("sb_en", {30'd0, ch_en}, {30'd0, mon_e.e});
            end
        end

    initial begin
        clear_model();
        repeat (3) @(negedge sys_clk);
        check("rst_ftw", ftw_out, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {24'd0, err_count}, 32'd0);
        rst = 1'b0;
        // commit immediate
        send(8'h00, 16'h1234);
        send(8'hC1, 16'h0000);
        @(negedge sys_clk);
        check("imm_pulse", {31'd0, update_pulse}, 32'd1);
        check("imm_ftw", ftw_out, 32'h0000_1234);
        @(negedge sys_clk);
        check("imm_pulse_1cyc", {31'd0, update_pulse}, 32'd0);
        // commit on wrap: phase holds until the wrap
        send(8'h41, 16'h0800);
        send(8'hC2, 16'h0000);
        ok_busy = 1'b1;
        ok_ph   = 1'b1;
        repeat (10) begin
            @(negedge sys_clk);
            ok_busy &= busy;
            ok_ph   &= (phase_out == 32'd0) && !update_pulse;
        end
        check("wait_busy", {31'd0, ok_busy}, 32'd1);
        check("wait_phase_hold", {31'd0, ok_ph}, 32'd1);
        wrap_pulse();
        check("wrap_pulse", {31'd0, update_pulse}, 32'd1);
        check("wrap_phase", phase_out, 32'h0800_0000);
        check("wrap_idle", {31'd0, busy}, 32'd0);
        wrap_pulse();
        check("idle_wrap_ignored", {31'd0, update_pulse}, 32'd0);
        // illegal index and system code
        send(8'h05, 16'hDEAD);
        send(8'hC7, 16'h0000);
        @(negedge sys_clk);
        check("illegal_err", {24'd0, err_count}, {24'd0, err_exp});
        check("illegal_ftw", ftw_out, act.f);
        check("illegal_phase", phase_out, act.p);
        // command coinciding with the wrap
        send(8'hC2, 16'h0000);
        repeat (3) @(negedge sys_clk);
        send(8'h01, 16'h00FF, 0, 1);
        repeat (3) @(negedge sys_clk);
        check("coinc_active_hold", ftw_out, 32'h0000_1234);
        send(8'hC1, 16'h0000);
        @(negedge sys_clk);
        check("coinc_shadow", ftw_out, 32'h00FF_1234);
        // pending slot full: second command dropped
        send(8'hC2, 16'h0000);
        send(8'h00, 16'hAAAA);
        send(8'h01, 16'hBBBB, 1);
        @(negedge sys_clk);
        check("drop_err", {24'd0, err_count}, {24'd0, err_exp});
        check("pend_busy", {31'd0, busy}, 32'd1);
        wrap_pulse();
        repeat (2) @(negedge sys_clk);
        send(8'hC1, 16'h0000);
        @(negedge sys_clk);
        check("pend_exec", ftw_out, 32'h00FF_AAAA);
        // control words, then clear shadows
        send(8'h80, 16'h0007);
        send(8'h81, 16'hFFF9);
        send(8'hC1, 16'h0000);
        @(negedge sys_clk);
        check("ctrl_wave", {28'd0, wave_sel}, 32'h7);
        check("ctrl_en", {30'd0, ch_en}, 32'h1);
        send(8'hFF, 16'h0000);
        send(8'hC1, 16'h0000);
        @(negedge sys_clk);
        check("clear_ftw", ftw_out, 32'd0);
        check("clear_en", {30'd0, ch_en}, 32'd0);
        // saturation
        repeat (300) send(8'h07, 16'h0000);
        @(negedge sys_clk);
        check("err_sat", {24'd0, err_count}, 32'd255);
        // reset mid-WAIT_WRAP
        send(8'h00, 16'h4321);
        send(8'hC1, 16'h0000);
        @(negedge sys_clk);
        send(8'h41, 16'h1111);
        send(8'hC2, 16'h0000);
        repeat (3) @(negedge sys_clk);
        check("prerst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("arst_ftw", ftw_out, 32'd0);
        check("arst_phase", phase_out, 32'd0);
        check("arst_ctl", {26'd0, wave_sel, ch_en}, 32'd0);
        check("arst_err", {24'd0, err_count}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_pulse", {31'd0, update_pulse}, 32'd0);
        sb.delete();
        clear_model();
        err_exp = '0;
        act = '0;
        @(negedge sys_clk);
        rst = 1'b0;
        wrap_pulse();
        check("rst_abandon", {31'd0, update_pulse}, 32'd0);
        check("rst_abandon_ph", phase_out, 32'd0);
        send(8'h01, 16'h5555);
        send(8'hC1, 16'h0000);
        @(negedge sys_clk);
        check("post_rst", ftw_out, 32'h5555_0000);
        repeat (2) @(negedge sys_clk);
        check("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
